rect_fill: RTL and testbench
============================

// Module: rect_fill
// PURPOSE
//  Rectangle fill engine: accepts one command (x, y, w, h, color) per valid/ready handshake.
//  Walks the rectangle in raster order and emits one pixel write per cycle.
//  Sits directly upstream of the framebuffer block RAM, driving its wr_ena/wr_addr/wr_data port.
//  The scanout side uses the RAM read port independently.
// PARAMETERS
//  FB_W   64  framebuffer width in pixels
//  FB_H   32  framebuffer height in pixels
//  W      8   pixel width in bits (matches framebuffer row width)
//  CW     8   coordinate/size width of cmd_x, cmd_y, cmd_w, cmd_h
//  localparam L = FB_W*FB_H; AW = $clog2(L)
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   asynchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   engine can accept a command
//  cmd_x      in   CW  left column
//  cmd_y      in   CW  top row
//  cmd_w      in   CW  width in pixels (0 allowed)
//  cmd_h      in   CW  height in pixels (0 allowed)
//  cmd_color  in   W   fill value
//  wr_ena     out  1   framebuffer write enable
//  wr_addr    out  AW  framebuffer address = y*FB_W + x
//  wr_data    out  W   pixel value (latched cmd_color)
//  busy       out  1   high from accept edge until done edge
//  done       out  1   one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset values:
//  - cmd_ready=0, wr_ena=0, wr_addr=0, wr_data=0, busy=0, done=0; state=IDLE.
//  - cmd_ready goes 1 on the first clk edge after rst deasserts.
//  Outputs:
//  - All outputs are registered; no combinational path from cmd_* to any output.
//  States and handshake:
//  - IDLE: cmd_ready=1. Accept when cmd_valid&&cmd_ready at edge E.
//  - At edge E: latch all cmd_* fields, cursor cx=cy=0, go to FILL.
//  - At edge E: cmd_ready=0, busy=1.
//  - FILL: one pixel per edge. Pixel writes are visible after edges E+1 .. E+w*h, with no gaps.
//  - Pixel order: x inner, y outer. Address = (cmd_y+cy)*FB_W + (cmd_x+cx).
//  - At edge E+w*h+1: wr_ena=0, done=1 for one cycle, busy=0, cmd_ready=1, state=IDLE.
//  - A new command is accepted no earlier than edge E+w*h+2.
//  Zero-size commands:
//  - w==0 or h==0: no writes.
//  - done pulses after edge E+1; cmd_ready returns at the same edge.
//  Arithmetic and command stability:
//  - Coordinate sums use CW+1 bits, so x+w never overflows internally.
//  - The address product is computed at full width, then truncated to AW bits (wrap modulo 2^AW).
//  - cmd_* may change freely after the accept edge; only latched copies are used.
//  - cmd_valid while busy is ignored and is not accepted.
//  Reset mid-fill:
//  - Immediately forces all outputs to reset values and state IDLE.
//  - The in-flight command is dropped and no done pulse is issued.
// CONFIGURATION
//  RECT_FILL_CLIP_EN defined:
//  - Pixels with (cmd_x+cx)>=FB_W or (cmd_y+cy)>=FB_H keep their cycle slot, but wr_ena=0 in that slot.
//  - Timing and the done edge are unchanged.
//  RECT_FILL_CLIP_EN undefined:
//  - No bounds check.
//  - Out-of-range pixels are written at the wrapped/truncated address given by the formula above.
// TESTING
//  1. FB_W=64: cmd (1,1,2,2,0xA5) -> after edges E+1..E+4: wr_addr 65,66,129,130, wr_data 0xA5.
//     -> done after E+5.
//  2. cmd (5,5,0,3,0x11) -> no wr_ena.
//     -> done after E+1, cmd_ready=1 at the same edge, busy high exactly one cycle.
//  3. cmd_valid held high with two commands (0,0,1,1) then (2,0,1,1)
//     -> writes to addr 0 then addr 2.
//     -> second accept at edge E+3, two done pulses total.
//  4. Clip: cmd (62,0,4,1,0xFF).
//     -> With RECT_FILL_CLIP_EN: writes to 62, 63 only, then wr_ena low for 2 slots, done after E+5.
//     -> Without the macro: writes to 62, 63, 64, 65.
//  5. Full frame (0,0,64,32,0x3C) -> 2048 consecutive writes, addr 0..2047, done after E+2049.
//  6. Assert rst during cycle 10 of a fill
//     -> wr_ena/busy/done/cmd_ready drop to 0 without waiting for clk.
//     -> cmd_ready=1 one edge after release, no done pulse.

Source files
------------

// File: rtl/rect_fill.sv
// rect_fill: rectangle fill engine. One command (x, y, w, h, color) is accepted
// per valid/ready handshake. The rectangle is walked in raster order (x inner,
// y outer) and one framebuffer write is emitted per clock.
//
// Optional feature: define RECT_FILL_CLIP_EN to suppress writes to pixels
// outside the FB_W x FB_H frame. Suppressed pixels keep their cycle slot.
// Without the macro, out-of-range pixels are written at the truncated address.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_x/cmd_y         top-left corner of the rectangle
//   cmd_w/cmd_h         rectangle size in pixels (0 allowed)
//   cmd_color           fill value
//   wr_ena/addr/data    framebuffer write port (addr = y*FB_W + x)
//   busy                high from the accept edge until the done edge
//   done                one-cycle pulse when a command completes
module rect_fill #(
  parameter int unsigned FB_W = 64,
  parameter int unsigned FB_H = 32,
  parameter int unsigned W    = 8,
  parameter int unsigned CW   = 8,
  localparam int unsigned L   = FB_W * FB_H,
  localparam int unsigned AW  = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_x,
  input  logic [CW-1:0] cmd_y,
  input  logic [CW-1:0] cmd_w,
  input  logic [CW-1:0] cmd_h,
  input  logic [W-1:0]  cmd_color,
  output logic          wr_ena,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          busy,
  output logic          done
);

  // Coordinate sums carry one extra bit so x+cx never wraps.
  localparam int unsigned SW = CW + 1;
  // Full-width product width before truncation to AW.
  localparam int unsigned PW = SW + $clog2(FB_W + 1) + 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [W-1:0]  color_q, color_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic          fin_q, fin_d;
  logic          ready_q, ready_d;
  logic          wr_ena_q, wr_ena_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [SW-1:0] xs_c, ys_c;
  logic [PW-1:0] addr_full_c;
  logic          pix_en_c;

  // Absolute pixel position and its linear address.
  assign xs_c        = SW'(x_q) + SW'(cx_q);
  assign ys_c        = SW'(y_q) + SW'(cy_q);
  assign addr_full_c = PW'(ys_c) * PW'(FB_W) + PW'(xs_c);

`ifdef RECT_FILL_CLIP_EN
  assign pix_en_c = (xs_c < SW'(FB_W)) && (ys_c < SW'(FB_H));
`else
  assign pix_en_c = 1'b1;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      fin_q     <= 1'b0;
      ready_q   <= 1'b0;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      color_q   <= color_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      fin_q     <= fin_d;
      ready_q   <= ready_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and output logic. fin_q marks that every pixel slot is spent.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    fin_d     = fin_q;
    ready_d   = ready_q;
    wr_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          cx_d    = '0;
          cy_d    = '0;
          fin_d   = (cmd_w == '0) || (cmd_h == '0);
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (fin_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wr_ena_d  = pix_en_c;
          wr_addr_d = AW'(addr_full_c);
          wr_data_d = color_q;
          if (cx_q == CW'(w_q - CW'(1))) begin
            cx_d = '0;
            if (cy_q == CW'(h_q - CW'(1))) begin
              fin_d = 1'b1;
            end else begin
              cy_d = CW'(cy_q + CW'(1));
            end
          end else begin
            cx_d = CW'(cx_q + CW'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = ready_q;
  assign wr_ena    = wr_ena_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill. Inputs change on the falling edge, outputs
// are sampled on the falling edge that follows each rising edge.
module tb_rect_fill;

  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_x, cmd_y, cmd_w, cmd_h, cmd_color;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  rect_fill dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at falling edges until the engine is ready.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(cmd_ready), 32'd1);
  endtask

  // Present a command, wait for acceptance edge E, return at the falling edge after E.
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                       input logic [7:0] h, input logic [7:0] c, input string tag);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x = 8'($urandom); cmd_y = 8'($urandom);
    cmd_w = 8'($urandom); cmd_h = 8'($urandom); cmd_color = 8'($urandom);
  endtask

  initial begin
    logic [31:0] exp_a [4];
    logic [3:0]  exp_en;
    int good;
    int d0;

    rst = 1'b1; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_outs", {27'd0, wr_ena, busy, done, 2'b0}, 32'd0);
    chk("rst_addr_data", {13'd0, wr_addr, wr_data}, 32'd0);
    rst = 1'b0;
    #1 chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // 1: 2x2 at (1,1)
    exp_a[0] = 65; exp_a[1] = 66; exp_a[2] = 129; exp_a[3] = 130;
    issue(8'd1, 8'd1, 8'd2, 8'd2, 8'hA5, "t1_accept");
    chk("t1_busy_ready", {30'd0, busy, cmd_ready}, 32'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_ena", 32'(wr_ena), 32'd1);
      chk("t1_addr", 32'(wr_addr), exp_a[k]);
      chk("t1_data", 32'(wr_data), 32'hA5);
      chk("t1_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("t1_done", {28'd0, done, busy, cmd_ready, wr_ena}, 32'b1010);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // 2: zero width
    d0 = done_cnt;
    issue(8'd5, 8'd5, 8'd0, 8'd3, 8'h11, "t2_accept");
    chk("t2_e", {29'd0, busy, cmd_ready, wr_ena}, 32'b100);
    @(negedge clk);
    chk("t2_done", {28'd0, done, busy, cmd_ready, wr_ena}, 32'b1010);
    @(negedge clk);
    chk("t2_after", {30'd0, done, busy}, 32'd0);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 3: valid held high across two back-to-back commands
    d0 = done_cnt;
    cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 8'd1; cmd_h = 8'd1; cmd_color = 8'h5A;
    cmd_valid = 1'b1;
    wait_ready("t3_ready");
    @(posedge clk);
    @(negedge clk);
    cmd_x = 8'd2; cmd_color = 8'h6B;
    chk("t3_e", {30'd0, busy, cmd_ready}, 32'b10);
    @(negedge clk);
    chk("t3_w0", {19'd0, wr_ena, wr_addr, 1'b0} | 32'(wr_data) << 24, {19'd0, 1'b1, 11'd0, 1'b0} | 32'h5A << 24);
    @(negedge clk);
    chk("t3_done0", {29'd0, done, cmd_ready, wr_ena}, 32'b110);
    @(negedge clk);
    chk("t3_accept2", {29'd0, busy, cmd_ready, done}, 32'b100);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_w1_ena", 32'(wr_ena), 32'd1);
    chk("t3_w1_addr", 32'(wr_addr), 32'd2);
    chk("t3_w1_data", 32'(wr_data), 32'h6B);
    @(negedge clk);
    chk("t3_done1", 32'(done), 32'd1);
    @(negedge clk);
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd2);

    // 4: rectangle crossing the right edge
`ifdef RECT_FILL_CLIP_EN
    exp_en = 4'b0011;
`else
    exp_en = 4'b1111;
`endif
    exp_a[0] = 62; exp_a[1] = 63; exp_a[2] = 64; exp_a[3] = 65;
    issue(8'd62, 8'd0, 8'd4, 8'd1, 8'hFF, "t4_accept");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_ena", 32'(wr_ena), 32'(exp_en[k]));
      if (exp_en[k]) begin
        chk("t4_addr", 32'(wr_addr), exp_a[k]);
        chk("t4_data", 32'(wr_data), 32'hFF);
      end
      chk("t4_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("t4_done", {30'd0, done, wr_ena}, 32'b10);

    // 5: full frame
    good = 0;
    issue(8'd0, 8'd0, 8'd64, 8'd32, 8'h3C, "t5_accept");
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      if (wr_ena === 1'b1 && wr_addr === AW'(k) && wr_data === 8'h3C && done === 1'b0) good++;
    end
    chk("t5_pixels", 32'(good), 32'd2048);
    @(negedge clk);
    chk("t5_done", {29'd0, done, busy, wr_ena}, 32'b100);

    // 6: reset in the middle of a fill
    issue(8'd0, 8'd0, 8'd20, 8'd1, 8'h77, "t6_accept");
    repeat (10) @(negedge clk);
    chk("t6_pre_ena", 32'(wr_ena), 32'd1);
    chk("t6_pre_addr", 32'(wr_addr), 32'd9);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("t6_async", {28'd0, wr_ena, busy, done, cmd_ready}, 32'd0);
    chk("t6_async_bus", {13'd0, wr_addr, wr_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("t6_ready_held", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("t6_ready", {29'd0, cmd_ready, busy, done}, 32'b100);
    repeat (25) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_idle", {30'd0, busy, wr_ena}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
